router_ingress_arbiter: RTL
===========================

Name: router_ingress_arbiter

Overview:
- Store-and-forward ingress scheduler placed in front of router_top's single input port (packet_valid/datain/busy).
- Shares that port between N packet sources, using round-robin arbitration.
- Buffers one complete packet, then validates it: destination address must not be 2'b11 and the packet must have even parity. A good packet is replayed to the router with the exact packet_valid framing the router expects. A bad packet is dropped and flagged.

Parameters:
- N_SRC, 3, number of requesting sources (2..8).
- MAX_LEN, 63, largest payload length; a 6-bit field in the header.
- BUF_DEPTH, 66, packet buffer bytes. Must be at least MAX_LEN+2 (header + payload + parity).

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  synchronous, active-low reset.
- src_valid  in  N_SRC  per-source byte valid.
- src_data  in  8*N_SRC  per-source byte; source k occupies bits [8k+7:8k].
- src_ready  out  N_SRC  per-source byte accepted this cycle.
- grant  out  N_SRC  one-hot: owner of the buffer. All zero when idle.
- rtr_pkt_valid  out  1  drives router packet_valid.
- rtr_data  out  8  drives router datain.
- rtr_busy  in  1  router busy; the byte is held while it is high.
- drop_addr  out  1  one-cycle pulse: packet dropped, address 3.
- drop_par  out  1  one-cycle pulse: packet dropped, parity error.
- arb_idle  out  1  high in IDLE.

Behaviour:
- Reset (resetn=0 sampled at posedge):
  - State goes to IDLE; all pointers and counters are 0; rr_last = N_SRC-1, so source 0 wins first.
  - Outputs: src_ready=0, grant=0, rtr_pkt_valid=0, rtr_data=0, drop_*=0, arb_idle=1.
  - Reset mid-packet discards the buffered packet. Outputs are zero from the following cycle.
- Byte handshake: a source byte transfers when src_valid[k] & src_ready[k]. Sources may insert bubbles freely.
- Packet format:
  - Byte 0 is the header: len=hdr[7:2], addr=hdr[1:0].
  - len payload bytes follow, then 1 parity byte. Total = len+2; len=0 is legal (2 bytes).
  - The parity byte equals the XOR of the header and all payload bytes.
- IDLE:
  - If any src_valid is set, grant the first requester found searching from rr_last+1 upward, with modulo wrap.
  - grant is registered on the next edge, then go to COLLECT.
  - Requests arriving in the same cycle are resolved by RR order only.
- COLLECT:
  - src_ready[g]=1; all other src_ready=0.
  - Each accepted byte is written to buf[wr_ptr] and XORed into par_acc; wr_ptr increments.
  - The byte at wr_ptr=0 latches the header.
  - When the byte at wr_ptr = len+1 is accepted, go to CHECK, with src_ready low from the next cycle.
- CHECK (1 cycle), priority order:
  - addr==3: pulse drop_addr, go to IDLE.
  - Otherwise par_acc!=0: pulse drop_par, go to IDLE.
  - Otherwise go to SEND with rd_ptr=0.
  - rr_last=g is updated on every exit from CHECK, including drops.
- SEND:
  - rtr_data=buf[rd_ptr].
  - rtr_pkt_valid=1 while rd_ptr<=len; it is 0 for the parity byte (rd_ptr=len+1).
  - The byte is consumed at a posedge where rtr_busy=0, and rd_ptr increments. When rtr_busy=1, rtr_data and rtr_pkt_valid hold unchanged.
  - After the parity byte is consumed, go to GAP.
  - The router outputs derive from registered state only; there is no combinational path from rtr_busy or src_* to rtr_*.
- GAP (1 cycle): rtr_pkt_valid=0, rtr_data=0, grant cleared; then go to IDLE. Minimum inter-packet spacing is therefore 1 idle cycle plus the IDLE/grant cycle.
- Latency: first router byte appears (len+2) accepted bytes + 2 cycles after the grant.
- Width rules:
  - wr_ptr and rd_ptr are clog2(BUF_DEPTH) bits wide; neither wraps within a packet.
  - Headers with len>MAX_LEN cannot occur, since len is a 6-bit field.

Decomposition:
- Shared package router_pkg:
  - HDR_ADDR_LSB/MSB, HDR_LEN_LSB/MSB.
  - ADDR_INVALID=2'b11.
  - arbiter state encoding: IDLE, COLLECT, CHECK, SEND, GAP.
- Sub-module router_pkt_buf:
  - BUF_DEPTH x 8 storage.
  - Synchronous write, asynchronous read.
  - Write/read pointer ports.

Test Plan:
- Single source: src0 sends hdr 8'h20 (len 8, addr 0), 8 payload bytes, correct parity, rtr_busy=0 -> 10 router bytes in order; rtr_pkt_valid high for 9 bytes and low on the parity byte; then 1 GAP cycle.
- Round-robin: all three sources valid from reset with len=2 packets -> grant order src0, src1, src2, src0. No source is granted twice while another is waiting.
- Busy stall: assert rtr_busy for 3 cycles on payload byte 4 -> rtr_data/rtr_pkt_valid frozen for 3 cycles; no byte lost or duplicated.
- Drops:
  - hdr 8'h0B (addr 3) -> drop_addr pulses once; no router activity.
  - Wrong parity byte -> drop_par pulses once; no router activity.
  - In both cases the next requester is then granted.
- Source bubbles: src1 drops src_valid every other cycle during a len=5 packet -> router stream is contiguous and identical to the bubble-free case.
- Reset mid-SEND: resetn=0 at byte 3 -> next cycle rtr_pkt_valid=0, grant=0, arb_idle=1. After release, src0 wins first.

Source files
------------

// File: rtl/router_pkg.sv
// router_pkg: shared definitions for the router ingress arbiter.
//   - header field positions (byte 0 of every packet)
//   - the destination address the router cannot accept
//   - arbiter state encoding
package router_pkg;

    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_LEN_MSB  = 7;

    localparam logic [1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_CHECK   = 3'd2,
        ST_SEND    = 3'd3,
        ST_GAP     = 3'd4
    } arb_state_e;

endpackage

// File: rtl/router_pkt_buf.sv
// router_pkt_buf: single-packet byte store.
//   clk      - system clock
//   wr_en    - write wr_data at wr_ptr on the rising edge
//   wr_ptr   - write address
//   wr_data  - byte to store
//   rd_ptr   - read address
//   rd_data  - byte at rd_ptr (combinational read)
module router_pkt_buf #(
    parameter int DEPTH = 66,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_ptr,
    input  logic [7:0]       wr_data,
    input  logic [PTR_W-1:0] rd_ptr,
    output logic [7:0]       rd_data
);

    logic [7:0] mem [DEPTH];

    // No reset: contents are only read back after a full packet was written.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/router_ingress_arbiter.sv
// router_ingress_arbiter: store-and-forward ingress scheduler in front of the
// router's single input port. Round-robin picks one of N_SRC sources, the
// whole packet (header, payload, parity) is buffered, checked, then either
// replayed to the router or dropped.
//   clk, resetn    - clock, synchronous active-low reset
//   src_valid/data - per-source byte stream (source k at src_data[8k+7:8k])
//   src_ready      - per-source byte accepted this cycle
//   grant          - one-hot buffer owner, zero when idle
//   rtr_pkt_valid  - router packet_valid
//   rtr_data       - router datain
//   rtr_busy       - router busy, holds the current byte
//   drop_addr      - pulse: packet dropped for address 3
//   drop_par       - pulse: packet dropped for parity error
//   arb_idle       - arbiter is in IDLE
module router_ingress_arbiter
    import router_pkg::*;
#(
    parameter int N_SRC     = 3,
    parameter int MAX_LEN   = 63,
    parameter int BUF_DEPTH = 66
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [N_SRC-1:0]   src_valid,
    input  logic [8*N_SRC-1:0] src_data,
    output logic [N_SRC-1:0]   src_ready,
    output logic [N_SRC-1:0]   grant,
    output logic               rtr_pkt_valid,
    output logic [7:0]         rtr_data,
    input  logic               rtr_busy,
    output logic               drop_addr,
    output logic               drop_par,
    output logic               arb_idle
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int SEL_W = $clog2(N_SRC);

    if (BUF_DEPTH < MAX_LEN + 2) begin : g_bad_depth
        $error("BUF_DEPTH must hold MAX_LEN+2 bytes");
    end

    arb_state_e       state;
    logic [N_SRC-1:0] grant_r;
    logic [SEL_W-1:0] g_idx;
    logic [SEL_W-1:0] rr_last;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [7:0]       hdr;
    logic [7:0]       par_acc;
    logic             drop_addr_r;
    logic             drop_par_r;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic [7:0]       in_byte;
    logic             accept;
    logic [PTR_W-1:0] len_p;
    logic [PTR_W-1:0] last_ptr;
    logic [7:0]       buf_rd;

    // Round-robin search starting just after the last served source.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 1; i <= N_SRC; i++) begin
            automatic int idx = (int'(rr_last) + i) % N_SRC;
            if (!pick_found && src_valid[idx]) begin
                pick_found = 1'b1;
                pick_idx   = SEL_W'(idx);
            end
        end
    end

    assign in_byte  = src_data[8*g_idx +: 8];
    assign accept   = (state == ST_COLLECT) && src_valid[g_idx];
    assign len_p    = PTR_W'(hdr[HDR_LEN_MSB:HDR_LEN_LSB]);
    assign last_ptr = len_p + PTR_W'(1);

    router_pkt_buf #(.DEPTH(BUF_DEPTH), .PTR_W(PTR_W)) u_buf (
        .clk     (clk),
        .wr_en   (accept),
        .wr_ptr  (wr_ptr),
        .wr_data (in_byte),
        .rd_ptr  (rd_ptr),
        .rd_data (buf_rd)
    );

    // Router side decodes only registered state; rtr_busy never reaches it.
    assign src_ready     = (state == ST_COLLECT) ? grant_r : '0;
    assign grant         = grant_r;
    assign arb_idle      = (state == ST_IDLE);
    assign rtr_pkt_valid = (state == ST_SEND) && (rd_ptr <= len_p);
    assign rtr_data      = (state == ST_SEND) ? buf_rd : 8'h00;
    assign drop_addr     = drop_addr_r;
    assign drop_par      = drop_par_r;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            grant_r     <= '0;
            g_idx       <= '0;
            rr_last     <= SEL_W'(N_SRC - 1);
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            hdr         <= '0;
            par_acc     <= '0;
            drop_addr_r <= 1'b0;
            drop_par_r  <= 1'b0;
        end else begin
            drop_addr_r <= 1'b0;
            drop_par_r  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_r           <= '0;
                        grant_r[pick_idx] <= 1'b1;
                        g_idx             <= pick_idx;
                        wr_ptr            <= '0;
                        par_acc           <= '0;
                        state             <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (accept) begin
                        wr_ptr  <= wr_ptr + PTR_W'(1);
                        par_acc <= par_acc ^ in_byte;
                        if (wr_ptr == '0)
                            hdr <= in_byte;
                        // len is only known once the header is in, so the
                        // first byte can never be the last one.
                        if (wr_ptr != '0 && wr_ptr == last_ptr)
                            state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    rr_last <= g_idx;
                    rd_ptr  <= '0;
                    if (hdr[HDR_ADDR_MSB:HDR_ADDR_LSB] == ADDR_INVALID) begin
                        drop_addr_r <= 1'b1;
                        grant_r     <= '0;
                        state       <= ST_IDLE;
                    end else if (par_acc != 8'h00) begin
                        // par_acc includes the parity byte, so a good packet XORs to 0
                        drop_par_r <= 1'b1;
                        grant_r    <= '0;
                        state      <= ST_IDLE;
                    end else begin
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!rtr_busy) begin
                        if (rd_ptr == last_ptr) begin
                            grant_r <= '0;
                            state   <= ST_GAP;
                        end else begin
                            rd_ptr <= rd_ptr + PTR_W'(1);
                        end
                    end
                end
                ST_GAP:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
